// File: rtl/sd_block_reader.sv
// SD-card single-block (CMD17) reader in SPI mode.
// Drives a byte-wide SPI engine over start/done, owns chip select, streams the payload bytes.
module sd_block_reader #(
    parameter int unsigned R1_TIMEOUT    = 16,
    parameter int unsigned TOKEN_TIMEOUT = 2048,
    parameter int unsigned BLOCK_BYTES   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_done,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        rd_err,
    output logic [3:0]  err_code,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [8:0]  byte_idx,
    output logic        spi_start,
    output logic [7:0]  spi_tx,
    input  logic [7:0]  spi_rx,
    input  logic        spi_done,
    output logic        cs,
    output logic [15:0] debug
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_PRE   = 4'd1,
        S_CMD   = 4'd2,
        S_R1    = 4'd3,
        S_TOKEN = 4'd4,
        S_DATA  = 4'd5,
        S_CRC   = 4'd6,
        S_FIN   = 4'd7,
        S_ERR   = 4'd8
    } state_e;

    localparam logic [11:0] R1_LIM    = 12'(R1_TIMEOUT);
    localparam logic [11:0] TOK_LIM   = 12'(TOKEN_TIMEOUT);
    localparam logic [11:0] DATA_LAST = 12'(BLOCK_BYTES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] poll_inc;
    logic        pend_q, pend_d;
    logic        start_q, start_d;
    logic [7:0]  tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        dv_q, dv_d;
    logic [7:0]  dout_q, dout_d;
    logic [8:0]  bidx_q, bidx_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  code_q, code_d;
    logic [7:0]  r1_q, r1_d;
    logic        cs_q, cs_d;

    assign poll_inc = (&cnt_q) ? cnt_q : cnt_q + 12'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= 8'hFF;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            dout_q  <= '0;
            bidx_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            r1_q    <= '0;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            dout_q  <= dout_d;
            bidx_q  <= bidx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            r1_q    <= r1_d;
            cs_q    <= cs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        start_d = 1'b0;
        tx_d    = tx_q;
        busy_d  = busy_q;
        dv_d    = 1'b0;
        dout_d  = dout_q;
        bidx_d  = bidx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        r1_d    = r1_q;

        if (dv_q && (&bidx_q)) bidx_d = '0;

        if (state_q == S_IDLE) begin
            if (rd_req) begin
                if (init_done) begin
                    addr_d  = rd_addr;
                    busy_d  = 1'b1;
                    code_d  = 4'd0;
                    cnt_d   = '0;
                    bidx_d  = '0;
                    state_d = S_PRE;
                end else begin
                    err_d  = 1'b1;
                    code_d = 4'd1;
                end
            end
        end else if (!pend_q) begin
            // One transfer in flight at a time; a new one starts the cycle after spi_done clears pend.
            start_d = 1'b1;
            pend_d  = 1'b1;
            tx_d    = 8'hFF;
            if (state_q == S_CMD) begin
                case (cnt_q[2:0])
                    3'd0:    tx_d = 8'h51;
                    3'd1:    tx_d = addr_q[31:24];
                    3'd2:    tx_d = addr_q[23:16];
                    3'd3:    tx_d = addr_q[15:8];
                    3'd4:    tx_d = addr_q[7:0];
                    default: tx_d = 8'hFF;
                endcase
            end
        end else if (spi_done) begin
            pend_d = 1'b0;
            case (state_q)
                S_PRE: begin
                    cnt_d   = '0;
                    state_d = S_CMD;
                end
                S_CMD: begin
                    if (cnt_q == 12'd5) begin
                        cnt_d   = '0;
                        state_d = S_R1;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_R1: begin
                    r1_d = spi_rx;
                    if (spi_rx == 8'h00) begin
                        cnt_d   = '0;
                        state_d = S_TOKEN;
                    end else if (spi_rx == 8'hFF) begin
                        cnt_d = poll_inc;
                        if (poll_inc >= R1_LIM) begin
                            code_d  = 4'd2;
                            state_d = S_ERR;
                        end
                    end else begin
                        code_d  = 4'd3;
                        state_d = S_ERR;
                    end
                end
                S_TOKEN: begin
                    if (spi_rx == 8'hFE) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else if (spi_rx[7:4] == 4'h0) begin
                        code_d  = 4'd5;
                        state_d = S_ERR;
                    end else begin
                        cnt_d = poll_inc;
                        if (poll_inc >= TOK_LIM) begin
                            code_d  = 4'd4;
                            state_d = S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    dv_d   = 1'b1;
                    dout_d = spi_rx;
                    bidx_d = cnt_q[8:0];
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end
                S_CRC: begin
                    if (cnt_q == 12'd1) state_d = S_FIN;
                    else cnt_d = cnt_q + 12'd1;
                end
                S_FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                S_ERR: begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        cs_d = !(state_d inside {S_PRE, S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC});
    end

    assign rd_busy    = busy_q;
    assign rd_done    = done_q;
    assign rd_err     = err_q;
    assign err_code   = code_q;
    assign data_out   = dout_q;
    assign data_valid = dv_q;
    assign byte_idx   = bidx_q;
    assign spi_start  = start_q;
    assign spi_tx     = tx_q;
    assign cs         = cs_q;
    assign debug      = {state_q, code_q, r1_q};

endmodule
